// File: rtl/gbt_elink_frame_assembler.sv
// Purpose: packs consecutive e-link words into one wide frame (first word in MSBs) and flags gaps and dropped frames.
// Latency: frm_valid rises one cycle after the last word of a frame is sampled; error pulses are one cycle after their cause.
// Backpressure: one-deep output register; a frame completing while a frame is held and not accepted is dropped (err_ovf).
// Optional statistics counters are enabled by defining GBT_ELINK_ASM_STATS_EN.
module gbt_elink_frame_assembler #(
  parameter int WORD_W          = 10,
  parameter int WORDS_PER_FRAME = 8,
  parameter int CNT_W           = 16
) (
  input  logic                              sClk,
  input  logic                              sRst_n,
  input  logic                              link_rdy,
  input  logic [WORD_W-1:0]                 elink_data,
  input  logic                              elink_valid,
  output logic [WORD_W*WORDS_PER_FRAME-1:0] frm_data,
  output logic                              frm_valid,
  input  logic                              frm_ready,
  output logic                              err_gap,
  output logic                              err_ovf,
  output logic [CNT_W-1:0]                  cnt_frames,
  output logic [CNT_W-1:0]                  cnt_errors
);

  localparam int FRM_W = WORD_W * WORDS_PER_FRAME;
  localparam int ASM_W = WORD_W * (WORDS_PER_FRAME - 1);
  localparam int WC_W  = $clog2(WORDS_PER_FRAME);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_FRAME - 1);

  typedef enum logic {DOWN, COLLECT} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [ASM_W-1:0]  asm_q;
  logic [FRM_W-1:0]  frame_new;
  logic              shift_en, frm_done, gap_d, ovf_d, load_frm, xfer;

  // Only the newest WORDS_PER_FRAME-1 words are kept; the current word completes the frame.
  assign frame_new = {asm_q, elink_data};
  assign xfer      = frm_valid & frm_ready;
  assign load_frm  = frm_done & (~frm_valid | frm_ready);
  assign ovf_d     = frm_done & frm_valid & ~frm_ready;

  // Next-state and word-count logic; link loss discards a partial frame without flagging it.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    shift_en = 1'b0;
    frm_done = 1'b0;
    gap_d    = 1'b0;
    case (state_q)
      DOWN: begin
        wcnt_d = '0;
        if (link_rdy) state_d = COLLECT;
      end
      COLLECT: begin
        if (!link_rdy) begin
          state_d = DOWN;
          wcnt_d  = '0;
        end else if (elink_valid) begin
          shift_en = 1'b1;
          if (wcnt_q == WC_LAST) begin
            frm_done = 1'b1;
            wcnt_d   = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (wcnt_q != '0) begin
          gap_d  = 1'b1;
          wcnt_d = '0;
        end
      end
    endcase
  end

  // State and word-counter registers.
  always_ff @(posedge sClk or negedge sRst_n) begin
    if (!sRst_n) begin
      state_q <= DOWN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Assembly shift register; stale words age out because a frame always needs a full run of words.
  always_ff @(posedge sClk or negedge sRst_n) begin
    if (!sRst_n) asm_q <= '0;
    else if (shift_en) asm_q <= frame_new[ASM_W-1:0];
  end

  // Output holding register: loads a completed frame when empty or being drained this cycle.
  always_ff @(posedge sClk or negedge sRst_n) begin
    if (!sRst_n) begin
      frm_valid <= 1'b0;
      frm_data  <= '0;
    end else if (load_frm) begin
      frm_valid <= 1'b1;
      frm_data  <= frame_new;
    end else if (xfer) begin
      frm_valid <= 1'b0;
    end
  end

  // Registered error pulses.
  always_ff @(posedge sClk or negedge sRst_n) begin
    if (!sRst_n) begin
      err_gap <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_gap <= gap_d;
      err_ovf <= ovf_d;
    end
  end

`ifdef GBT_ELINK_ASM_STATS_EN
  logic [CNT_W:0] err_sum;
  assign err_sum = {1'b0, cnt_errors} + (CNT_W+1)'(err_gap) + (CNT_W+1)'(err_ovf);

  // Saturating statistics: delivered frames and error events (both errors in one cycle count as two).
  always_ff @(posedge sClk or negedge sRst_n) begin
    if (!sRst_n) begin
      cnt_frames <= '0;
      cnt_errors <= '0;
    end else begin
      if (xfer && (cnt_frames != '1)) cnt_frames <= cnt_frames + 1'b1;
      cnt_errors <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end
`else
  assign cnt_frames = '0;
  assign cnt_errors = '0;
`endif

endmodule
